// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for alu_arbiter: request channel plus the tagged response strobe.
interface alu_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_unsig;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_result;
  logic               resp_compout;
  logic               resp_overflow;
  logic               resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_unsig,
    input  req_ready, resp_valid, resp_result, resp_compout, resp_overflow, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_unsig,
    output req_ready, resp_valid, resp_result, resp_compout, resp_overflow, resp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of the shared combinational ALU.
// Define ALU_ARB_RR_EN for round-robin conflict resolution; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic        clk,
  input  logic        reset,
  alu_arbiter_if.slave bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_unsig,
  input  logic [31:0] alu_out,
  input  logic        alu_compout,
  input  logic        alu_overflow
);

  // state | meaning
  // IDLE  | grant combinationally, latch request on accept
  // EXEC  | alu_* hold the request, ALU outputs captured at cycle end
  // RESP  | one-cycle response strobe to the owner
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic            sel;
  logic            legal;
  logic            owner;
  logic            last_grant;
  logic [2:0]      sel_op;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            sel_unsig;

  always_comb begin
    grant = '0;
    case (bus.req_valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef ALU_ARB_RR_EN
        grant = last_grant ? 2'b01 : 2'b10;
`else
        grant = 2'b01;
`endif
      end
      default: grant = '0;
    endcase
  end

`ifndef ALU_ARB_RR_EN
  // Still tracked so both builds share identical state behaviour.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  assign sel       = grant[1];
  assign sel_op    = sel ? bus.req_op[5:3]    : bus.req_op[2:0];
  assign sel_a     = sel ? bus.req_a[63:32]   : bus.req_a[31:0];
  assign sel_b     = sel ? bus.req_b[63:32]   : bus.req_b[31:0];
  assign sel_unsig = sel ? bus.req_unsig[1]   : bus.req_unsig[0];
  assign legal     = (sel_op[1:0] != 2'b11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) bus.req_ready = grant;
        accept = |(bus.req_valid & bus.req_ready);
        if (accept) state_nxt = legal ? EXEC : RESP;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        bus.resp_valid = owner ? 2'b10 : 2'b01;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner             <= 1'b0;
      last_grant        <= 1'b1;
      alu_a             <= '0;
      alu_b             <= '0;
      alu_op            <= '0;
      alu_unsig         <= 1'b0;
      bus.resp_result   <= '0;
      bus.resp_compout  <= 1'b0;
      bus.resp_overflow <= 1'b0;
      bus.resp_err      <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= sel;
        last_grant <= sel;
        if (legal) begin
          alu_a        <= sel_a;
          alu_b        <= sel_b;
          alu_op       <= sel_op;
          alu_unsig    <= sel_unsig;
          bus.resp_err <= 1'b0;
        end else begin
          // Illegal opcodes never reach the ALU; the response is a zeroed error.
          bus.resp_result   <= '0;
          bus.resp_compout  <= 1'b0;
          bus.resp_overflow <= 1'b0;
          bus.resp_err      <= 1'b1;
        end
      end
      if (state == EXEC) begin
        bus.resp_result   <= alu_out;
        bus.resp_compout  <= alu_compout;
        bus.resp_overflow <= alu_overflow;
      end
    end
  end

endmodule
